sync_sram_array: RTL and testbench

Synchronous, multi-way SRAM array model for the set-associative cache datapath, generalising the earlier asynchronous single-array model. It holds WAYS parallel data arrays indexed by one set address, reads all ways in one access for tag/data lookup, and writes any subset of ways with byte granularity. It adds a configurable read pipeline, a defined read-during-write mode, and a sequenced array-clear engine with a busy indication.

---
 rtl/sync_sram_array_if.sv | 30 +++
 rtl/sync_sram_array.sv | 146 ++++++++++++++
 tb/tb_sync_sram_array.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_sram_array_if.sv
// Request/response bundle between the cache datapath and the multi-way SRAM array.
// The datapath side uses master; the array uses slave.
interface sync_sram_array_if #(
    parameter int WIDTH     = 32,
    parameter int WAYS      = 4,
    parameter int BYTE_W    = 8,
    parameter int ADDR_BITS = 8
);
    logic [ADDR_BITS-1:0]    Addr;
    logic                    RdEn;
    logic                    WrEn;
    logic [WAYS-1:0]         WayWrEn;
    logic [WIDTH/BYTE_W-1:0] ByteEn;
    logic [WIDTH-1:0]        WrData;
    logic                    Clear;
    logic [WAYS*WIDTH-1:0]   RdData;
    logic                    RdValid;
    logic                    Busy;
    logic                    Dropped;

    modport master (
        output Addr, RdEn, WrEn, WayWrEn, ByteEn, WrData, Clear,
        input  RdData, RdValid, Busy, Dropped
    );

    modport slave (
        input  Addr, RdEn, WrEn, WayWrEn, ByteEn, WrData, Clear,
        output RdData, RdValid, Busy, Dropped
    );
endinterface

// File: rtl/sync_sram_array.sv
// Multi-way synchronous SRAM array: all ways read per access, byte-masked writes to any
// subset of ways, 1- or 2-cycle read pipeline, and a row-by-row clear engine with Busy.
module sync_sram_array #(
    parameter int DEPTH      = 256,
    parameter int WIDTH      = 32,
    parameter int WAYS       = 4,
    parameter int BYTE_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input logic              Clk,
    input logic              RstN,
    sync_sram_array_if.slave bus
);
    localparam int NBYTES = WIDTH / BYTE_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] cnt_nxt;
    logic                 idle;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 dropped;
    logic [WAYS*WIDTH-1:0] rd_row;
    logic [WAYS*WIDTH-1:0] rdata_p0;
    logic                  vld_p0;

    logic [WIDTH-1:0] mem [WAYS][DEPTH];

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  old_row,
                                                     input logic [WIDTH-1:0]  new_row,
                                                     input logic [NBYTES-1:0] be);
        logic [WIDTH-1:0] res;
        res = old_row;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) res[b*BYTE_W +: BYTE_W] = new_row[b*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    assign idle   = (state == IDLE);
    assign rd_acc = bus.RdEn && idle;
    assign wr_acc = bus.WrEn && idle;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The clear engine walks every row once; a Clear seen while already clearing is ignored.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.Clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR_BITS'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int d = 0; d < DEPTH; d++) mem[w][d] <= '0;
            end
        end else if (!idle) begin
            for (int w = 0; w < WAYS; w++) mem[w][cnt] <= '0;
        end else if (wr_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.WayWrEn[w]) mem[w][bus.Addr] <= merge_bytes(mem[w][bus.Addr], bus.WrData, bus.ByteEn);
            end
        end
    end

    // With RDW_MODE=1 a same-cycle write is forwarded into the read result byte by byte.
    always_comb begin
        rd_row = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (RDW_MODE != 0 && wr_acc && bus.WayWrEn[w])
                rd_row[w*WIDTH +: WIDTH] = merge_bytes(mem[w][bus.Addr], bus.WrData, bus.ByteEn);
            else
                rd_row[w*WIDTH +: WIDTH] = mem[w][bus.Addr];
        end
    end

    // Stage p0: array read register; holds its value between reads.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            vld_p0  <= rd_acc;
            dropped <= (bus.RdEn || bus.WrEn) && !idle;
            if (rd_acc) rdata_p0 <= rd_row;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [WAYS*WIDTH-1:0] rdata_p1;
            logic                  vld_p1;

            // Stage p1: optional output register.
            always_ff @(posedge Clk or negedge RstN) begin
                if (!RstN) begin
                    rdata_p1 <= '0;
                    vld_p1   <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) rdata_p1 <= rdata_p0;
                end
            end

            assign bus.RdData  = rdata_p1;
            assign bus.RdValid = vld_p1;
        end else begin : g_lat1
            assign bus.RdData  = rdata_p0;
            assign bus.RdValid = vld_p0;
        end
    endgenerate

    assign bus.Busy    = !idle;
    assign bus.Dropped = dropped;
endmodule

// File: tb/tb_sync_sram_array.sv
// Bench for sync_sram_array: two instances (latency 1/old-data and latency 2/new-data)
// share one stimulus stream and are compared each cycle against a behavioural model.
module tb_sync_sram_array;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        clr;
        logic [7:0]  addr;
        logic [3:0]  way;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  way;
        logic [3:0]  be;
        logic [31:0] data;
        logic        rdw;
        int          cw;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sync_sram_array_if #(.WIDTH(32), .WAYS(4), .BYTE_W(8), .ADDR_BITS(8)) bus0 ();
    sync_sram_array_if #(.WIDTH(32), .WAYS(4), .BYTE_W(8), .ADDR_BITS(8)) bus1 ();

    sync_sram_array #(.DEPTH(DEPTH), .WIDTH(32), .WAYS(4), .BYTE_W(8),
                      .RD_LATENCY(1), .RDW_MODE(0)) dut0 (.Clk(clk), .RstN(rst_n), .bus(bus0));
    sync_sram_array #(.DEPTH(DEPTH), .WIDTH(32), .WAYS(4), .BYTE_W(8),
                      .RD_LATENCY(2), .RDW_MODE(1)) dut1 (.Clk(clk), .RstN(rst_n), .bus(bus1));

    // Reference model state
    logic [31:0]  m [4][DEPTH];
    int           busy_left;
    logic         edrop, ev0, ev1, p_acc;
    logic [127:0] e0, e1, p_new;
    req_t         cur;

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 4; w++)
            for (int d = 0; d < DEPTH; d++) m[w][d] = '0;
        busy_left = 0;
        edrop = 0; ev0 = 0; ev1 = 0; p_acc = 0;
        e0 = '0; e1 = '0; p_new = '0;
    endtask

    task automatic model_edge();
        logic         busy_b, acc;
        logic [127:0] ov, nv;
        busy_b = busy_left > 0;
        edrop  = (cur.rd || cur.wr) && busy_b;
        acc    = cur.rd && !busy_b;
        ov = '0;
        nv = '0;
        for (int w = 0; w < 4; w++) begin
            ov[w*32 +: 32] = m[w][cur.addr];
            nv[w*32 +: 32] = (cur.wr && cur.way[w]) ? mrg(m[w][cur.addr], cur.data, cur.be) : m[w][cur.addr];
        end
        ev1 = p_acc;
        if (p_acc) e1 = p_new;
        p_acc = acc;
        if (acc) p_new = nv;
        ev0 = acc;
        if (acc) e0 = ov;
        if (busy_b) begin
            busy_left--;
        end else begin
            if (cur.wr)
                for (int w = 0; w < 4; w++)
                    if (cur.way[w]) m[w][cur.addr] = mrg(m[w][cur.addr], cur.data, cur.be);
            if (cur.clr) begin
                for (int w = 0; w < 4; w++)
                    for (int d = 0; d < DEPTH; d++) m[w][d] = '0;
                busy_left = DEPTH;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("busy0",  128'(bus0.Busy),    128'(busy_left > 0));
        chk("busy1",  128'(bus1.Busy),    128'(busy_left > 0));
        chk("drop0",  128'(bus0.Dropped), 128'(edrop));
        chk("drop1",  128'(bus1.Dropped), 128'(edrop));
        chk("valid0", 128'(bus0.RdValid), 128'(ev0));
        chk("valid1", 128'(bus1.RdValid), 128'(ev1));
        chk("data0",  bus0.RdData, e0);
        chk("data1",  bus1.RdData, e1);
    endtask

    task automatic drive(input req_t r);
        cur = r;
        bus0.Addr = r.addr; bus0.RdEn = r.rd; bus0.WrEn = r.wr; bus0.Clear = r.clr;
        bus0.WayWrEn = r.way; bus0.ByteEn = r.be; bus0.WrData = r.data;
        bus1.Addr = r.addr; bus1.RdEn = r.rd; bus1.WrEn = r.wr; bus1.Clear = r.clr;
        bus1.WayWrEn = r.way; bus1.ByteEn = r.be; bus1.WrData = r.data;
    endtask

    task automatic step(input req_t r);
        drive(r);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic req_t rd_req(input logic [7:0] a);
        req_t r = '0;
        r.rd = 1'b1;
        r.addr = a;
        return r;
    endfunction

    function automatic req_t wr_req(input logic [7:0] a, input logic [3:0] way, input logic [3:0] be, input logic [31:0] d);
        req_t r = '0;
        r.wr = 1'b1; r.addr = a; r.way = way; r.be = be; r.data = d;
        return r;
    endfunction

    vec_t vt [8];

    initial begin
        req_t        r;
        int          bc, dc, v0c, v1c;
        logic [31:0] acc_or;
        logic        v1 [6];
        logic [31:0] d1 [6];

        vt[0] = '{8'h10, 4'b0100, 4'hF, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{8'h10, 4'b0000, 4'hF, 32'h12345678, 1'b0, 0, 32'h0,        32'h0};
        vt[2] = '{8'h20, 4'b1111, 4'hF, 32'h11223344, 1'b0, 1, 32'h11223344, 32'h11223344};
        vt[3] = '{8'h20, 4'b1111, 4'h5, 32'hAABBCCDD, 1'b0, 3, 32'h11BB33DD, 32'h11BB33DD};
        vt[4] = '{8'h05, 4'b1111, 4'hF, 32'h55AA55AA, 1'b1, 0, 32'h0,        32'h55AA55AA};
        vt[5] = '{8'h05, 4'b0000, 4'h0, 32'h0,        1'b0, 0, 32'h55AA55AA, 32'h55AA55AA};
        vt[6] = '{8'h20, 4'b1111, 4'h0, 32'hFFFFFFFF, 1'b0, 2, 32'h11BB33DD, 32'h11BB33DD};
        vt[7] = '{8'h30, 4'b0001, 4'h8, 32'h12345678, 1'b1, 0, 32'h0,        32'h12000000};

        drive('0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vt[i]) begin
            r = wr_req(vt[i].addr, vt[i].way, vt[i].be, vt[i].data);
            r.rd = vt[i].rdw;
            step(r);
            if (!vt[i].rdw) step(rd_req(vt[i].addr));
            step('0);
            step('0);
            chk($sformatf("vec%0d_lat1", i), 128'(bus0.RdData[vt[i].cw*32 +: 32]), 128'(vt[i].exp0));
            chk($sformatf("vec%0d_lat2", i), 128'(bus1.RdData[vt[i].cw*32 +: 32]), 128'(vt[i].exp1));
        end

        // Back-to-back reads through the two-stage pipeline
        step(wr_req(8'd1, 4'hF, 4'hF, 32'hA1));
        step(wr_req(8'd2, 4'hF, 4'hF, 32'hA2));
        step(wr_req(8'd3, 4'hF, 4'hF, 32'hA3));
        for (int k = 0; k < 6; k++) begin
            step(k < 3 ? rd_req(8'(k + 1)) : req_t'('0));
            v1[k] = bus1.RdValid;
            d1[k] = bus1.RdData[31:0];
        end
        chk("b2b_first_gap", 128'(v1[0]), 128'(0));
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("b2b_valid%0d", k), 128'(v1[k]), 128'(1));
            chk($sformatf("b2b_data%0d", k), 128'(d1[k]), 128'(32'hA0 + k));
        end
        chk("b2b_done", 128'(v1[4]), 128'(0));

        // Fill, then clear while hammering reads
        for (int a = 0; a < DEPTH; a++) step(wr_req(8'(a), 4'hF, 4'hF, 32'hFFFFFFFF));
        step(rd_req(8'd7));
        r = rd_req(8'd9);
        r.clr = 1'b1;
        step(r);
        bc = bus0.Busy ? 1 : 0;
        dc = 0; v0c = 0; v1c = 0;
        for (int k = 0; k < DEPTH + 20 && bus0.Busy; k++) begin
            step(rd_req(8'(k)));
            if (bus0.Busy) bc++;
            if (bus0.Dropped) dc++;
            if (bus0.RdValid) v0c++;
            if (bus1.RdValid) v1c++;
        end
        chk("clear_busy_cycles", 128'(bc), 128'(DEPTH));
        chk("clear_drops", 128'(dc), 128'(DEPTH));
        chk("clear_valid_lat1", 128'(v0c), 128'(0));
        chk("clear_valid_lat2", 128'(v1c), 128'(1));
        acc_or = '0;
        for (int a = 0; a < DEPTH; a++) begin
            step(rd_req(8'(a)));
            acc_or |= bus0.RdData[31:0] | bus0.RdData[63:32] | bus0.RdData[95:64] | bus0.RdData[127:96];
        end
        chk("cleared_rows", 128'(acc_or), 128'(0));

        // Reset in the middle of a clear
        step(wr_req(8'd7, 4'hF, 4'hF, 32'hCAFEF00D));
        step(wr_req(8'd200, 4'hF, 4'hF, 32'h0BADF00D));
        step(rd_req(8'd7));
        r = '0;
        r.clr = 1'b1;
        step(r);
        for (int k = 0; k < 100; k++) step('0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy0",  128'(bus0.Busy), 128'(0));
        chk("rst_busy1",  128'(bus1.Busy), 128'(0));
        chk("rst_valid0", 128'(bus0.RdValid), 128'(0));
        chk("rst_data0",  bus0.RdData, 128'(0));
        chk("rst_data1",  bus1.RdData, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_or = '0;
        for (int a = 0; a < DEPTH; a++) begin
            step(rd_req(8'(a)));
            acc_or |= bus0.RdData[31:0] | bus0.RdData[63:32] | bus0.RdData[95:64] | bus0.RdData[127:96];
        end
        chk("rst_rows_zero", 128'(acc_or), 128'(0));

        // Randomized traffic on a small address window
        for (int k = 0; k < 500; k++) begin
            r = '0;
            r.rd   = $urandom_range(0, 1);
            r.wr   = $urandom_range(0, 1);
            r.addr = 8'($urandom_range(0, 15));
            r.way  = 4'($urandom);
            r.be   = 4'($urandom);
            r.data = $urandom;
            r.clr  = ($urandom_range(0, 199) == 0);
            step(r);
        end
        for (int k = 0; k < 3; k++) step('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
